prbs_seq_ctrl: RTL and testbench

- Sequencer for the team's pattern-then-PRBS byte generator.
- On a start command it latches a pattern byte, a repeat count and a PRBS length.
- It emits the pattern byte n times, then prbs_len PRBS15 bytes, over a valid/ready byte stream, then pulses done.
- Sits between the test-control register block and the serializer/TX lane.

---
 rtl/prbs_pkg.sv | 23 ++
 rtl/prbs15_step8.sv | 25 ++
 rtl/prbs_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_prbs_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types and PRBS15 helpers for the pattern-then-PRBS sequencer.
// The LFSR uses x^15+x^14+1 and shifts toward the MSB, inserting the feedback bit at bit 0.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PATTERN = 2'd1,
    ST_PRBS    = 2'd2
  } state_e;

  localparam int PRBS_W = 15;
  localparam int TAP_HI = 14;
  localparam int TAP_LO = 13;
  localparam logic [PRBS_W-1:0] DEFAULT_SEED = 15'h0011;

  // Returns {next_state, feedback_bit}.
  function automatic logic [PRBS_W:0] lfsr_step(input logic [PRBS_W-1:0] s);
    logic f;
    f = s[TAP_HI] ^ s[TAP_LO];
    return {s[PRBS_W-2:0], f, f};
  endfunction

endpackage

// File: rtl/prbs15_step8.sv
// Combinational eight-step PRBS15 advance.
// Yields one output byte (first generated bit in bit 7) and the LFSR state after the byte.
module prbs15_step8
  import prbs_pkg::*;
(
  input  logic [PRBS_W-1:0] i_state,
  output logic [7:0]        o_byte,
  output logic [PRBS_W-1:0] o_state_next
);

  always_comb begin
    logic [PRBS_W-1:0] v_s;
    logic [PRBS_W:0]   v_r;
    v_s    = i_state;
    v_r    = '0;
    o_byte = '0;
    for (int i = 0; i < 8; i++) begin
      v_r           = lfsr_step(v_s);
      o_byte[7-i]   = v_r[0];
      v_s           = v_r[PRBS_W:1];
    end
    o_state_next = v_s;
  end

endmodule

// File: rtl/prbs_seq_ctrl.sv
// Sequencer that emits a pattern byte n times, then prbs_len PRBS15 bytes, then pulses done.
// Sits between the test-control registers and the serializer lane.
module prbs_seq_ctrl
  import prbs_pkg::*;
#(
  parameter int                LEN_W = 16,
  parameter logic [PRBS_W-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [7:0]       pattern,
  input  logic [7:0]       n,
  input  logic [LEN_W-1:0] prbs_len,
  input  logic             abort,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_is_prbs,
  output logic             busy,
  output logic             done
);

  // Handshake: a byte moves when out_valid & out_ready are both high at a rising
  // edge; while out_valid is high and out_ready low, out_data, out_is_prbs, the
  // counters and the LFSR hold, and out_valid never drops without a transfer
  // (other than on RST or abort).

  state_e            r_state;
  logic [7:0]        r_pattern;
  logic [7:0]        r_n;
  logic [7:0]        r_rep_cnt;
  logic [LEN_W-1:0]  r_prbs_len;
  logic [LEN_W-1:0]  r_prbs_cnt;
  logic [PRBS_W-1:0] r_lfsr;
  logic              r_valid;
  logic              r_is_prbs;
  logic              r_busy;
  logic              r_done;

  logic [7:0]        w_prbs_byte;
  logic [PRBS_W-1:0] w_lfsr_next;
  logic              w_xfer;
  logic              w_last_rep;
  logic              w_last_prbs;

  prbs15_step8 u_step8 (
    .i_state      (r_lfsr),
    .o_byte       (w_prbs_byte),
    .o_state_next (w_lfsr_next)
  );

  assign w_xfer      = r_valid & out_ready;
  assign w_last_rep  = (r_rep_cnt == (r_n - 8'd1));
  assign w_last_prbs = (r_prbs_cnt == (r_prbs_len - LEN_W'(1)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_pattern  <= '0;
      r_n        <= '0;
      r_rep_cnt  <= '0;
      r_prbs_len <= '0;
      r_prbs_cnt <= '0;
      r_lfsr     <= SEED;
      r_valid    <= 1'b0;
      r_is_prbs  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state    <= ST_IDLE;
        r_rep_cnt  <= '0;
        r_prbs_cnt <= '0;
        r_valid    <= 1'b0;
        r_is_prbs  <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_pattern  <= pattern;
              r_n        <= n;
              r_prbs_len <= prbs_len;
              r_rep_cnt  <= '0;
              r_prbs_cnt <= '0;
              r_lfsr     <= SEED;
              if (n != 8'd0) begin
                r_state   <= ST_PATTERN;
                r_valid   <= 1'b1;
                r_busy    <= 1'b1;
                r_is_prbs <= 1'b0;
              end else if (prbs_len != '0) begin
                r_state   <= ST_PRBS;
                r_valid   <= 1'b1;
                r_busy    <= 1'b1;
                r_is_prbs <= 1'b1;
              end else begin
                r_done <= 1'b1;
              end
            end
          end
          ST_PATTERN: begin
            if (w_xfer) begin
              if (w_last_rep) begin
                if (r_prbs_len != '0) begin
                  r_state   <= ST_PRBS;
                  r_is_prbs <= 1'b1;
                end else begin
                  r_state <= ST_IDLE;
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end else begin
                r_rep_cnt <= r_rep_cnt + 8'd1;
              end
            end
          end
          ST_PRBS: begin
            if (w_xfer) begin
              r_lfsr <= w_lfsr_next;
              if (w_last_prbs) begin
                r_state   <= ST_IDLE;
                r_valid   <= 1'b0;
                r_busy    <= 1'b0;
                r_is_prbs <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_prbs_cnt <= r_prbs_cnt + LEN_W'(1);
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_data    = r_valid ? (r_is_prbs ? w_prbs_byte : r_pattern) : 8'h00;
  assign out_valid   = r_valid;
  assign out_is_prbs = r_is_prbs;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_prbs_seq_ctrl.sv
// Self-checking bench for prbs_seq_ctrl: vector table, hand-written corner sequences
// and randomized runs scored against a PRBS15 recurrence model.
module tb_prbs_seq_ctrl;

  localparam int          LEN_W   = 16;
  localparam logic [14:0] TB_SEED = 15'h0011;

  logic             CLK = 1'b0;
  logic             RST;
  logic             start;
  logic [7:0]       pattern;
  logic [7:0]       n;
  logic [LEN_W-1:0] prbs_len;
  logic             abort;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_is_prbs;
  logic             busy;
  logic             done;

  prbs_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .pattern     (pattern),
    .n           (n),
    .prbs_len    (prbs_len),
    .abort       (abort),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_is_prbs (out_is_prbs),
    .busy        (busy),
    .done        (done)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [8:0] exp_q[$];
  bit         ready_q[$];
  int         ready_pct = 100;
  bit         stray_en  = 0;
  logic [8:0] first_byte;
  logic [8:0] last_byte;
  int         busy_cycles;

  typedef struct {
    logic [7:0]  pat;
    logic [7:0]  nn;
    logic [15:0] len;
    logic [8:0]  first;
    logic [8:0]  last;
    int          busy_exp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: pattern bytes, then bytes of x[k] = x[k-15] ^ x[k-14] with the seed as history.
  task automatic model_push(input logic [7:0] pat, input logic [7:0] nn, input logic [15:0] len);
    bit          hist[$];
    logic [14:0] seed_v;
    logic [7:0]  b;
    bit          nb;
    seed_v = TB_SEED;
    b = '0;
    for (int i = 0; i < int'(nn); i++) exp_q.push_back({1'b0, pat});
    for (int k = 14; k >= 0; k--) hist.push_back(seed_v[k]);
    for (int j = 0; j < int'(len); j++) begin
      for (int i = 0; i < 8; i++) begin
        nb = hist[0] ^ hist[1];
        hist.push_back(nb);
        void'(hist.pop_front());
        b[7-i] = nb;
      end
      exp_q.push_back({1'b1, b});
    end
  endtask

  // Driver: call positioned at a falling edge after that edge's outputs were sampled.
  task automatic issue_start(input logic [7:0] pat, input logic [7:0] nn, input logic [15:0] len);
    start    = 1'b1;
    pattern  = pat;
    n        = nn;
    prbs_len = len;
    model_push(pat, nn, len);
  endtask

  task automatic drain(input int exp_busy, input bit chain,
                       input logic [7:0] cpat, input logic [7:0] cn, input logic [15:0] clen);
    int         cyc, last_x, total;
    bit         got_done, prev_stall, rdy;
    logic [8:0] prev_b, cur;
    logic       v, p, b, dn;
    logic [7:0] d;
    total = exp_q.size();
    cyc = 0; last_x = 0; got_done = 0; prev_stall = 0; prev_b = '0;
    busy_cycles = 0; first_byte = '0; last_byte = '0;
    while (!got_done && cyc < 4000) begin
      @(negedge CLK);
      cyc++;
      v = out_valid; d = out_data; p = out_is_prbs; b = busy; dn = done;
      if (ready_q.size() > 0) rdy = ready_q.pop_front();
      else rdy = ($urandom_range(99) < ready_pct);
      out_ready = rdy;
      check("valid_eq_busy", 32'(v), 32'(b));
      if (cyc == 1 && total > 0) check("first_valid_latency", 32'(v), 32'd1);
      if (prev_stall) check("stall_hold", 32'({p, d}), 32'(prev_b));
      if (v && rdy) begin
        cur = {p, d};
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", cur);
        end else begin
          check("byte", 32'(cur), 32'(exp_q.pop_front()));
        end
        if (last_x == 0) first_byte = cur;
        last_byte = cur;
        last_x = cyc;
      end
      if (b) busy_cycles++;
      prev_stall = v && !rdy;
      prev_b = {p, d};
      if (dn) begin
        got_done = 1;
        check("done_latency", 32'(cyc), (total > 0) ? 32'(last_x + 1) : 32'd1);
        check("all_bytes_sent", 32'(exp_q.size()), 32'd0);
        check("done_not_busy", 32'(b), 32'd0);
      end
      if (dn && chain) issue_start(cpat, cn, clen);
      else if (b && stray_en && $urandom_range(1) == 1) begin
        start = 1'b1; pattern = 8'($urandom); n = 8'($urandom); prbs_len = 16'($urandom);
      end else start = 1'b0;
    end
    check("done_seen", 32'(got_done), 32'd1);
    if (!got_done) exp_q.delete();
    if (exp_busy >= 0) check("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
    if (!chain) begin
      @(negedge CLK);
      check("done_single_cycle", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(out_valid), 32'd0);
    end
  endtask

  // Start a sequence outside the scoreboard, then kill it with RST (use_rst) or abort.
  task automatic kill_mid(input bit use_rst);
    start = 1'b1; pattern = 8'hA5; n = 8'd5; prbs_len = 16'd4; out_ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    check("pre_kill_valid", 32'(out_valid), 32'd1);
    check("pre_kill_data", 32'({out_is_prbs, out_data}), 32'h0A5);
    if (use_rst) RST = 1'b1; else abort = 1'b1;
    @(negedge CLK);
    check("kill_valid", 32'(out_valid), 32'd0);
    check("kill_busy", 32'(busy), 32'd0);
    check("kill_done", 32'(done), 32'd0);
    RST = 1'b0; abort = 1'b0;
    ready_pct = 100;
    issue_start(8'h5A, 8'd0, 16'd1);
    drain(1, 0, 8'h00, 8'h00, 16'h0);
    check("reseed_first", 32'(first_byte), 32'h100);
  endtask

  initial begin
    logic [7:0]  rp, rn;
    logic [15:0] rl;
    RST = 1'b1; start = 1'b0; pattern = '0; n = '0; prbs_len = '0;
    abort = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_is_prbs", 32'(out_is_prbs), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    RST = 1'b0;

    // Vector table: {pattern, n, prbs_len, first {is_prbs,byte}, last, busy cycles}
    vecs[0] = '{8'hA5, 8'd3, 16'd2, 9'h0A5, 9'h166, 5};
    vecs[1] = '{8'h5C, 8'd0, 16'd2, 9'h100, 9'h166, 2};
    vecs[2] = '{8'h77, 8'd0, 16'd0, 9'h000, 9'h000, 0};
    vecs[3] = '{8'h3C, 8'd1, 16'd0, 9'h03C, 9'h03C, 1};
    vecs[4] = '{8'hC3, 8'd2, 16'd1, 9'h0C3, 9'h100, 3};
    ready_pct = 100;
    for (int i = 0; i < 5; i++) begin
      issue_start(vecs[i].pat, vecs[i].nn, vecs[i].len);
      drain(vecs[i].busy_exp, 0, 8'h00, 8'h00, 16'h0);
      if (vecs[i].busy_exp > 0) begin
        check("vec_first", 32'(first_byte), 32'(vecs[i].first));
        check("vec_last", 32'(last_byte), 32'(vecs[i].last));
      end
    end

    // Backpressure during PRBS: ready 1,0,0,1 across the 00/66 bytes
    ready_q = '{1, 1, 1, 1, 0, 0, 1};
    issue_start(8'hA5, 8'd3, 16'd2);
    drain(7, 0, 8'h00, 8'h00, 16'h0);
    check("bp_last", 32'(last_byte), 32'h166);

    // Reset and abort mid-sequence, each followed by a reseed check
    kill_mid(1);
    kill_mid(0);

    // Starts while busy are ignored
    stray_en = 1;
    issue_start(8'h99, 8'd4, 16'd3);
    drain(7, 0, 8'h00, 8'h00, 16'h0);

    // Back-to-back: start in the done cycle
    stray_en = 0;
    issue_start(8'h11, 8'd2, 16'd1);
    drain(3, 1, 8'h22, 8'd1, 16'd2);
    drain(3, 0, 8'h00, 8'h00, 16'h0);
    check("b2b_first", 32'(first_byte), 32'h022);

    // Randomized sequences
    stray_en = 1;
    for (int t = 0; t < 25; t++) begin
      ready_pct = (t % 4 == 0) ? 100 : int'($urandom_range(30, 100));
      rp = 8'($urandom);
      rn = (t == 3) ? 8'd255 : 8'($urandom_range(0, 6));
      rl = (t == 7) ? 16'd300 : 16'($urandom_range(0, 24));
      issue_start(rp, rn, rl);
      drain((ready_pct == 100) ? int'(rn) + int'(rl) : -1, 0, 8'h00, 8'h00, 16'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
